// File: rtl/wallace_mul_pipe_if.sv
// Operand/result handshake bundle for wallace_mul_pipe.
// master drives operands and out_ready; slave is the multiplier.
interface wallace_mul_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_res;

    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, out_res
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, out_res
    );
endinterface

// File: rtl/wallace_mul_pipe.sv
// Three-stage pipelined Wallace-tree multiplier, WIDTH x WIDTH -> 2*WIDTH.
// S1 registers operands, S2 registers the reduced sum/carry rows,
// S3 registers the final carry-propagate addition. Signed mode uses
// Baugh-Wooley partial products so one tree serves both modes.
module wallace_mul_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    wallace_mul_pipe_if.slave  bus
);
    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned MAXH   = WIDTH + 2;
    localparam int unsigned LEVELS = 10;

    // Stage registers
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sgn;
    logic             r_v1;
    logic [PW-1:0]    r_sum;
    logic [PW-1:0]    r_carry;
    logic             r_v2;
    logic [PW-1:0]    r_res;
    logic             r_v3;

    // Reduction tree working storage (columns of bits, per-column heights)
    logic [MAXH-1:0]  w_col  [PW];
    logic [MAXH-1:0]  w_nxt  [PW];
    int unsigned      w_h    [PW];
    int unsigned      w_nh   [PW];
    int unsigned      w_maxh;
    logic             w_pp;
    logic             w_x;
    logic             w_y;
    logic             w_z;
    logic [PW-1:0]    w_sum;
    logic [PW-1:0]    w_carry;
    logic             w_stall;

    assign w_stall       = r_v3 && !bus.out_ready;
    assign bus.in_ready  = !w_stall;
    assign bus.out_valid = r_v3;
    assign bus.out_res   = r_res;

    // Partial-product generation and greedy 3:2/2:2 column reduction to two rows.
    // The mode bit is pushed as the Baugh-Wooley constant bits so the tree
    // shape is identical in both modes (they contribute 0 when unsigned).
    always_comb begin
        for (int unsigned c = 0; c < PW; c++) begin
            w_col[c] = '0;
            w_nxt[c] = '0;
            w_h[c]   = 0;
            w_nh[c]  = 0;
        end
        w_maxh = 0;
        w_pp   = 1'b0;
        w_x    = 1'b0;
        w_y    = 1'b0;
        w_z    = 1'b0;

        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                w_pp = r_a[j] & r_b[i];
                if (r_sgn && ((i == WIDTH - 1) != (j == WIDTH - 1))) begin
                    w_pp = ~w_pp;
                end
                w_col[i+j][w_h[i+j]] = w_pp;
                w_h[i+j] = w_h[i+j] + 1;
            end
        end
        w_col[WIDTH][w_h[WIDTH]] = r_sgn;
        w_h[WIDTH] = w_h[WIDTH] + 1;
        w_col[PW-1][w_h[PW-1]] = r_sgn;
        w_h[PW-1] = w_h[PW-1] + 1;

        for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
            w_maxh = 0;
            for (int unsigned c = 0; c < PW; c++) begin
                if (w_h[c] > w_maxh) begin
                    w_maxh = w_h[c];
                end
            end
            if (w_maxh > 2) begin
                for (int unsigned c = 0; c < PW; c++) begin
                    w_nxt[c] = '0;
                    w_nh[c]  = 0;
                end
                for (int unsigned c = 0; c < PW; c++) begin
                    for (int unsigned k = 0; k < MAXH; k += 3) begin
                        if (k + 2 < w_h[c]) begin
                            w_x = w_col[c][k];
                            w_y = w_col[c][k+1];
                            w_z = w_col[c][k+2];
                            w_nxt[c][w_nh[c]] = w_x ^ w_y ^ w_z;
                            w_nh[c] = w_nh[c] + 1;
                            if (c + 1 < PW) begin
                                w_nxt[c+1][w_nh[c+1]] = (w_x & w_y) | (w_x & w_z) | (w_y & w_z);
                                w_nh[c+1] = w_nh[c+1] + 1;
                            end
                        end else if (k + 1 < w_h[c]) begin
                            w_x = w_col[c][k];
                            w_y = w_col[c][k+1];
                            w_nxt[c][w_nh[c]] = w_x ^ w_y;
                            w_nh[c] = w_nh[c] + 1;
                            if (c + 1 < PW) begin
                                w_nxt[c+1][w_nh[c+1]] = w_x & w_y;
                                w_nh[c+1] = w_nh[c+1] + 1;
                            end
                        end else if (k < w_h[c]) begin
                            w_nxt[c][w_nh[c]] = w_col[c][k];
                            w_nh[c] = w_nh[c] + 1;
                        end
                    end
                end
                for (int unsigned c = 0; c < PW; c++) begin
                    w_col[c] = w_nxt[c];
                    w_h[c]   = w_nh[c];
                end
            end
        end

        for (int unsigned c = 0; c < PW; c++) begin
            w_sum[c]   = (w_h[c] > 0) ? w_col[c][0] : 1'b0;
            w_carry[c] = (w_h[c] > 1) ? w_col[c][1] : 1'b0;
        end
    end

    // Pipeline advance: all stages move together unless the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sgn   <= 1'b0;
            r_v1    <= 1'b0;
            r_sum   <= '0;
            r_carry <= '0;
            r_v2    <= 1'b0;
            r_res   <= '0;
            r_v3    <= 1'b0;
        end else if (!w_stall) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_a   <= bus.in_a;
                r_b   <= bus.in_b;
                r_sgn <= bus.in_signed;
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_sum   <= w_sum;
                r_carry <= w_carry;
            end
            r_v3 <= r_v2;
            if (r_v2) begin
                r_res <= r_sum + r_carry;
            end
        end
    end
endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Self-checking bench for wallace_mul_pipe at WIDTH=8 and WIDTH=16.
module tb_wallace_mul_pipe;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    wallace_mul_pipe_if #(.WIDTH(8))  b8  ();
    wallace_mul_pipe_if #(.WIDTH(16)) b16 ();

    wallace_mul_pipe #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    wallace_mul_pipe #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;
    int unsigned n_total = 0;
    logic [63:0] exp_q [$];

    // Reference: exact integer product of the operands taken as signed or
    // unsigned w-bit numbers, reduced to 2w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input bit s, input int unsigned w);
        longint sa;
        longint sb;
        longint p;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'(64'(a) & mask);
        sb = longint'(64'(b) & mask);
        if (s && a[w-1]) sa = sa - longint'(64'd1 << w);
        if (s && b[w-1]) sb = sb - longint'(64'd1 << w);
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit wide, input bit v, input logic [31:0] a,
                         input logic [31:0] b, input bit s);
        if (wide) begin
            b16.in_valid  = v;
            b16.in_a      = a[15:0];
            b16.in_b      = b[15:0];
            b16.in_signed = s;
        end else begin
            b8.in_valid  = v;
            b8.in_a      = a[7:0];
            b8.in_b      = b[7:0];
            b8.in_signed = s;
        end
    endtask

    function automatic logic [63:0] get_valid(input bit wide);
        return wide ? 64'(b16.out_valid) : 64'(b8.out_valid);
    endfunction

    function automatic logic [63:0] get_res(input bit wide);
        return wide ? 64'(b16.out_res) : 64'(b8.out_res);
    endfunction

    // One isolated operation: not visible after two edges, visible after three.
    task automatic single(input bit wide, input logic [31:0] a, input logic [31:0] b,
                          input bit s, input logic [63:0] exp, input string tag);
        @(posedge clk); #1;
        drive(wide, 1'b1, a, b, s);
        @(posedge clk); #1;
        drive(wide, 1'b0, '0, '0, 1'b0);
        @(posedge clk); @(negedge clk);
        check({tag, "_early"}, get_valid(wide), 64'd0);
        @(posedge clk); @(negedge clk);
        check({tag, "_valid"}, get_valid(wide), 64'd1);
        check(tag, get_res(wide), exp);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        b8.out_ready  = 1'b1;
        b16.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_valid8", get_valid(1'b0), 64'd0);
        check("rst_res8", get_res(1'b0), 64'd0);
        check("rst_valid16", get_valid(1'b1), 64'd0);
        #10 rst_n = 1'b1;
        #1;
        check("rst_in_ready8", 64'(b8.in_ready), 64'd1);
        check("rst_in_ready16", 64'(b16.in_ready), 64'd1);

        // Directed WIDTH=8
        single(1'b0, 32'hFF, 32'hFF, 1'b0, 64'hFE01, "u8_ff_ff");
        single(1'b0, 32'h00, 32'hA5, 1'b0, 64'h0000, "u8_0_a5");
        single(1'b0, 32'h80, 32'h80, 1'b1, 64'h4000, "s8_80_80");
        single(1'b0, 32'hFF, 32'h01, 1'b1, 64'hFFFF, "s8_ff_01");
        single(1'b0, 32'h80, 32'h7F, 1'b1, 64'hC080, "s8_80_7f");
        single(1'b0, 32'h7F, 32'h7F, 1'b1, 64'h3F01, "s8_7f_7f");

        // Directed WIDTH=16
        single(1'b1, 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE0001, "u16_ffff_ffff");
        single(1'b1, 32'h8000, 32'h8000, 1'b1, 64'h40000000, "s16_8000_8000");
        single(1'b1, 32'h8000, 32'h0001, 1'b1, 64'hFFFF8000, "s16_8000_0001");

        // Streaming, alternating mode, one result per cycle with latency 3
        exp_q.delete();
        for (int t = 0; t < 1003; t++) begin
            @(posedge clk); #1;
            if (t < 1000) begin
                ra = $urandom;
                rb = $urandom;
                rs = (t % 2) == 1;
                drive(1'b0, 1'b1, ra, rb, rs);
                exp_q.push_back(ref_mul(ra, rb, rs, 8));
            end else begin
                drive(1'b0, 1'b0, '0, '0, 1'b0);
            end
            @(negedge clk);
            if (t < 1000) check("stream_in_ready", 64'(b8.in_ready), 64'd1);
            if (t >= 3) begin
                check("stream_valid", get_valid(1'b0), 64'd1);
                if (exp_q.size() > 0) check("stream_res", get_res(1'b0), exp_q.pop_front());
            end else begin
                check("stream_fill", get_valid(1'b0), 64'd0);
            end
        end
        check("stream_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("stream_tail_empty", get_valid(1'b0), 64'd0);

        // Backpressure: 4 ops, then out_ready low for 5 cycles
        exp_q.delete();
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (k < 4) begin
                ra = $urandom;
                rb = $urandom;
                rs = (k % 2) == 0;
                drive(1'b0, 1'b1, ra, rb, rs);
                exp_q.push_back(ref_mul(ra, rb, rs, 8));
            end else begin
                drive(1'b0, 1'b0, '0, '0, 1'b0);
            end
            b8.out_ready = (k >= 4 && k < 9) ? 1'b0 : 1'b1;
            @(negedge clk);
            check("bp_valid", get_valid(1'b0), (k >= 3 && k <= 11) ? 64'd1 : 64'd0);
            check("bp_in_ready", 64'(b8.in_ready), (k >= 4 && k < 9) ? 64'd0 : 64'd1);
            if (k >= 4 && k < 9 && exp_q.size() > 0) check("bp_hold", get_res(1'b0), exp_q[0]);
            if (b8.out_valid && b8.out_ready) begin
                if (exp_q.size() > 0) check("bp_res", get_res(1'b0), exp_q.pop_front());
                else check("bp_extra", 64'd1, 64'd0);
            end
        end
        check("bp_all_delivered", 64'(exp_q.size()), 64'd0);

        // Reset mid-operation
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b1, 32'(k + 3), 32'h11, 1'b0);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        #2;
        check("mid_pre_valid", get_valid(1'b0), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", get_valid(1'b0), 64'd0);
        check("mid_rst_res", get_res(1'b0), 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("mid_no_stale", get_valid(1'b0), 64'd0);
        end
        single(1'b0, 32'h5A, 32'hC3, 1'b0, ref_mul(32'h5A, 32'hC3, 1'b0, 8), "mid_after_u");
        single(1'b0, 32'h9C, 32'h37, 1'b1, ref_mul(32'h9C, 32'h37, 1'b1, 8), "mid_after_s");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
